// File: rtl/id_issue_stage.sv
// ---------------------------------------------------------------------------
// id_issue_stage
//  Decode/issue stage. Fetched {pc, inst} pairs are buffered in a small queue;
//  the queue head is decoded combinationally, its operands are resolved
//  (immediate, $0, EX forward, MEM forward, regfile) and it is issued into a
//  registered ID/EX slot. Load-use hazards against the slot hold the head.
//  Branches and jumps resolve at issue and produce a one-cycle redirect pulse.
//
//  Optional feature macro: ID_DELAY_SLOT_EN
//    defined   : the first instruction younger than a taken branch survives
//                the flush, and the link address is pc+8.
//    undefined : every younger instruction is flushed, link address is pc+4.
//
//  Ports
//    clk, rst                 clock, asynchronous active-low reset
//    if_valid_i/if_ready_o    fetch handshake, if_pc_i/if_inst_i payload
//    reg1/2_addr_o, _data_i   regfile read ports, addressed by head rs/rt
//    ex_*/mem_*               EX and MEM write-back results for forwarding
//    id_valid_o/ex_ready_i    ID/EX slot handshake
//    aluop_o..pc_o            registered slot contents
//    branch_flag_o/_target_o  one-cycle redirect pulse and target
//    inst_err_o               one-cycle pulse: unsupported opcode issued as NOP
//    stall_cnt_o              saturating count of load-use stall cycles
// ---------------------------------------------------------------------------
module id_issue_stage #(
    parameter int DATA_W    = 32,
    parameter int REG_AW    = 5,
    parameter int BUF_DEPTH = 2,
    parameter int CNT_W     = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_valid_i,
    output logic              if_ready_o,
    input  logic [DATA_W-1:0] if_pc_i,
    input  logic [31:0]       if_inst_i,
    output logic [REG_AW-1:0] reg1_addr_o,
    output logic [REG_AW-1:0] reg2_addr_o,
    input  logic [DATA_W-1:0] reg1_data_i,
    input  logic [DATA_W-1:0] reg2_data_i,
    input  logic              ex_wreg_i,
    input  logic [REG_AW-1:0] ex_wd_i,
    input  logic [DATA_W-1:0] ex_wdata_i,
    input  logic              mem_wreg_i,
    input  logic [REG_AW-1:0] mem_wd_i,
    input  logic [DATA_W-1:0] mem_wdata_i,
    output logic              id_valid_o,
    input  logic              ex_ready_i,
    output logic [7:0]        aluop_o,
    output logic [2:0]        alusel_o,
    output logic [DATA_W-1:0] reg1_o,
    output logic [DATA_W-1:0] reg2_o,
    output logic [REG_AW-1:0] wd_o,
    output logic              wreg_o,
    output logic              is_load_o,
    output logic [DATA_W-1:0] return_addr_o,
    output logic [31:0]       inst_o,
    output logic [DATA_W-1:0] pc_o,
    output logic              branch_flag_o,
    output logic [DATA_W-1:0] branch_target_o,
    output logic              inst_err_o,
    output logic [CNT_W-1:0]  stall_cnt_o
);
    localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
    localparam logic [PTR_W:0]   CNT_ONE = (PTR_W+1)'(1);
    localparam logic [PTR_W:0]   CNT_FULL = (PTR_W+1)'(BUF_DEPTH);

    localparam logic [5:0] OP_SPECIAL = 6'h00, OP_J = 6'h02, OP_JAL = 6'h03, OP_BEQ = 6'h04,
                           OP_BNE = 6'h05, OP_ADDIU = 6'h09, OP_SLTI = 6'h0A, OP_ANDI = 6'h0C,
                           OP_ORI = 6'h0D, OP_XORI = 6'h0E, OP_LUI = 6'h0F, OP_LW = 6'h23, OP_SW = 6'h2B;
    localparam logic [5:0] FN_SLL = 6'h00, FN_SRL = 6'h02, FN_JR = 6'h08, FN_JALR = 6'h09,
                           FN_ADDU = 6'h21, FN_SUBU = 6'h23, FN_AND = 6'h24, FN_OR = 6'h25,
                           FN_XOR = 6'h26, FN_SLT = 6'h2A;
    localparam logic [7:0] ALU_OP_NOP = 8'h00, ALU_OP_AND = 8'h24, ALU_OP_OR = 8'h25, ALU_OP_XOR = 8'h26,
                           ALU_OP_ADDU = 8'h21, ALU_OP_SUBU = 8'h23, ALU_OP_SLT = 8'h2A, ALU_OP_SLL = 8'h7C,
                           ALU_OP_SRL = 8'h02, ALU_OP_LW = 8'hE3, ALU_OP_SW = 8'hEB, ALU_OP_J = 8'h4F,
                           ALU_OP_JAL = 8'h50, ALU_OP_JR = 8'h08, ALU_OP_JALR = 8'h09, ALU_OP_BEQ = 8'h51,
                           ALU_OP_BNE = 8'h52;
    localparam logic [2:0] ALU_RES_NOP = 3'd0, ALU_RES_LOGIC = 3'd1, ALU_RES_SHIFT = 3'd2,
                           ALU_RES_ARITH = 3'd4, ALU_RES_JB = 3'd6, ALU_RES_LS = 3'd7;

    typedef enum logic [2:0] {BR_NONE = 3'd0, BR_EQ = 3'd1, BR_NE = 3'd2, BR_J = 3'd3, BR_REG = 3'd4} br_kind_e;

    // Queue storage and pointers
    logic [DATA_W-1:0] q_pc_q   [BUF_DEPTH];
    logic [31:0]       q_inst_q [BUF_DEPTH];
    logic [PTR_W-1:0]  rd_q, rd_d, wr_q, wr_d;
    logic [PTR_W:0]    cnt_q, cnt_d;
    logic              wr_en;

    // ID/EX slot
    logic              id_valid_q, wreg_q, is_load_q, branch_flag_q, inst_err_q;
    logic [7:0]        aluop_q;
    logic [2:0]        alusel_q;
    logic [DATA_W-1:0] reg1_q, reg2_q, ret_q, pc_q, target_q;
    logic [REG_AW-1:0] wd_q;
    logic [31:0]       inst_q;
    logic [CNT_W-1:0]  stall_cnt_q;

    // Head decode
    logic [31:0]       head_inst;
    logic [DATA_W-1:0] head_pc, pc4, op1, op2, imm1, imm2, br_target;
    logic [REG_AW-1:0] rs, rt, dec_wd;
    logic [7:0]        dec_aluop;
    logic [2:0]        dec_alusel;
    logic              head_valid, rd1_en, rd2_en, dec_wreg, dec_load, dec_err, br_cond;
    logic              push, load_use, issue, taken;
    br_kind_e          br_kind;

    // Operand resolution: immediate when the port is unused, then $0, EX, MEM, regfile.
    function automatic logic [DATA_W-1:0] pick_operand(
        input logic en, input logic [REG_AW-1:0] addr, input logic [DATA_W-1:0] imm,
        input logic [DATA_W-1:0] rf, input logic exw, input logic [REG_AW-1:0] exd,
        input logic [DATA_W-1:0] exv, input logic memw, input logic [REG_AW-1:0] memd,
        input logic [DATA_W-1:0] memv);
        logic [DATA_W-1:0] r;
        if (!en)                          r = imm;
        else if (addr == '0)              r = '0;
        else if (exw && (exd == addr))    r = exv;
        else if (memw && (memd == addr))  r = memv;
        else                              r = rf;
        return r;
    endfunction

    assign head_valid  = (cnt_q != '0);
    assign head_inst   = q_inst_q[rd_q];
    assign head_pc     = q_pc_q[rd_q];
    assign pc4         = head_pc + DATA_W'(4);
    assign rs          = REG_AW'(head_inst[25:21]);
    assign rt          = REG_AW'(head_inst[20:16]);
    assign reg1_addr_o = rs;
    assign reg2_addr_o = rt;
    assign if_ready_o  = (cnt_q != CNT_FULL);
    assign push        = if_valid_i && if_ready_o;

    // Combinational decode of the queue head
    always_comb begin
        dec_aluop = ALU_OP_NOP; dec_alusel = ALU_RES_NOP; dec_wreg = 1'b0; dec_wd = rt;
        rd1_en = 1'b0; rd2_en = 1'b0; imm1 = '0; imm2 = '0; dec_load = 1'b0; dec_err = 1'b0;
        br_kind = BR_NONE;
        case (head_inst[31:26])
            OP_SPECIAL: begin
                dec_wd = REG_AW'(head_inst[15:11]); dec_wreg = 1'b1; rd1_en = 1'b1; rd2_en = 1'b1;
                case (head_inst[5:0])
                    FN_AND:  begin dec_aluop = ALU_OP_AND;  dec_alusel = ALU_RES_LOGIC; end
                    FN_OR:   begin dec_aluop = ALU_OP_OR;   dec_alusel = ALU_RES_LOGIC; end
                    FN_XOR:  begin dec_aluop = ALU_OP_XOR;  dec_alusel = ALU_RES_LOGIC; end
                    FN_ADDU: begin dec_aluop = ALU_OP_ADDU; dec_alusel = ALU_RES_ARITH; end
                    FN_SUBU: begin dec_aluop = ALU_OP_SUBU; dec_alusel = ALU_RES_ARITH; end
                    FN_SLT:  begin dec_aluop = ALU_OP_SLT;  dec_alusel = ALU_RES_ARITH; end
                    // Shifts take the shift amount on port 1 and rt on port 2
                    FN_SLL:  begin dec_aluop = ALU_OP_SLL;  dec_alusel = ALU_RES_SHIFT; rd1_en = 1'b0;
                                   imm1 = {{(DATA_W-5){1'b0}}, head_inst[10:6]}; end
                    FN_SRL:  begin dec_aluop = ALU_OP_SRL;  dec_alusel = ALU_RES_SHIFT; rd1_en = 1'b0;
                                   imm1 = {{(DATA_W-5){1'b0}}, head_inst[10:6]}; end
                    FN_JR:   begin dec_aluop = ALU_OP_JR;   dec_alusel = ALU_RES_JB; dec_wreg = 1'b0;
                                   rd2_en = 1'b0; br_kind = BR_REG; end
                    FN_JALR: begin dec_aluop = ALU_OP_JALR; dec_alusel = ALU_RES_JB; rd2_en = 1'b0;
                                   br_kind = BR_REG; end
                    default: begin dec_wreg = 1'b0; rd1_en = 1'b0; rd2_en = 1'b0; dec_err = 1'b1; end
                endcase
            end
            OP_ORI:   begin dec_aluop = ALU_OP_OR;  dec_alusel = ALU_RES_LOGIC; dec_wreg = 1'b1; rd1_en = 1'b1;
                            imm2 = {{(DATA_W-16){1'b0}}, head_inst[15:0]}; end
            OP_ANDI:  begin dec_aluop = ALU_OP_AND; dec_alusel = ALU_RES_LOGIC; dec_wreg = 1'b1; rd1_en = 1'b1;
                            imm2 = {{(DATA_W-16){1'b0}}, head_inst[15:0]}; end
            OP_XORI:  begin dec_aluop = ALU_OP_XOR; dec_alusel = ALU_RES_LOGIC; dec_wreg = 1'b1; rd1_en = 1'b1;
                            imm2 = {{(DATA_W-16){1'b0}}, head_inst[15:0]}; end
            OP_LUI:   begin dec_aluop = ALU_OP_OR;  dec_alusel = ALU_RES_LOGIC; dec_wreg = 1'b1;
                            imm2 = {head_inst[15:0], {(DATA_W-16){1'b0}}}; end
            OP_ADDIU: begin dec_aluop = ALU_OP_ADDU; dec_alusel = ALU_RES_ARITH; dec_wreg = 1'b1; rd1_en = 1'b1;
                            imm2 = {{(DATA_W-16){head_inst[15]}}, head_inst[15:0]}; end
            OP_SLTI:  begin dec_aluop = ALU_OP_SLT; dec_alusel = ALU_RES_ARITH; dec_wreg = 1'b1; rd1_en = 1'b1;
                            imm2 = {{(DATA_W-16){head_inst[15]}}, head_inst[15:0]}; end
            OP_LW:    begin dec_aluop = ALU_OP_LW;  dec_alusel = ALU_RES_LS; dec_wreg = 1'b1; rd1_en = 1'b1;
                            dec_load = 1'b1; imm2 = {{(DATA_W-16){head_inst[15]}}, head_inst[15:0]}; end
            // Store data travels on port 2; EX takes the offset from inst_o
            OP_SW:    begin dec_aluop = ALU_OP_SW;  dec_alusel = ALU_RES_LS; rd1_en = 1'b1; rd2_en = 1'b1; end
            OP_BEQ:   begin dec_aluop = ALU_OP_BEQ; dec_alusel = ALU_RES_JB; rd1_en = 1'b1; rd2_en = 1'b1;
                            br_kind = BR_EQ; end
            OP_BNE:   begin dec_aluop = ALU_OP_BNE; dec_alusel = ALU_RES_JB; rd1_en = 1'b1; rd2_en = 1'b1;
                            br_kind = BR_NE; end
            OP_J:     begin dec_aluop = ALU_OP_J;   dec_alusel = ALU_RES_JB; br_kind = BR_J; end
            OP_JAL:   begin dec_aluop = ALU_OP_JAL; dec_alusel = ALU_RES_JB; dec_wreg = 1'b1;
                            dec_wd = REG_AW'(31); br_kind = BR_J; end
            default:  begin dec_err = 1'b1; end
        endcase
    end

    assign op1 = pick_operand(rd1_en, rs, imm1, reg1_data_i, ex_wreg_i, ex_wd_i, ex_wdata_i,
                              mem_wreg_i, mem_wd_i, mem_wdata_i);
    assign op2 = pick_operand(rd2_en, rt, imm2, reg2_data_i, ex_wreg_i, ex_wd_i, ex_wdata_i,
                              mem_wreg_i, mem_wd_i, mem_wdata_i);

    // Branch condition and target on the forwarded operands
    always_comb begin
        br_cond   = 1'b0;
        br_target = '0;
        case (br_kind)
            BR_EQ:   begin br_cond = (op1 == op2);
                           br_target = pc4 + {{(DATA_W-18){head_inst[15]}}, head_inst[15:0], 2'b00}; end
            BR_NE:   begin br_cond = (op1 != op2);
                           br_target = pc4 + {{(DATA_W-18){head_inst[15]}}, head_inst[15:0], 2'b00}; end
            BR_J:    begin br_cond = 1'b1; br_target = {pc4[DATA_W-1:28], head_inst[25:0], 2'b00}; end
            BR_REG:  begin br_cond = 1'b1; br_target = op1; end
            default: begin br_cond = 1'b0; br_target = '0; end
        endcase
    end

    // The slot's load result is not available to forward until it reaches MEM
    assign load_use = id_valid_q && is_load_q && wreg_q && (wd_q != '0) &&
                      ((rd1_en && (rs == wd_q)) || (rd2_en && (rt == wd_q)));
    assign issue    = head_valid && !load_use && (!id_valid_q || ex_ready_i);
    assign taken    = issue && br_cond;

    // Queue pointer/count next state, including flush on a taken branch
    always_comb begin
        rd_d = rd_q; wr_d = wr_q; cnt_d = cnt_q; wr_en = 1'b0;
        if (taken) begin
`ifdef ID_DELAY_SLOT_EN
            if (cnt_q > CNT_ONE) begin
                // Keep only the entry right behind the branch
                rd_d = rd_q + PTR_ONE; wr_d = rd_q + PTR_W'(2); cnt_d = CNT_ONE;
            end else if (push) begin
                wr_en = 1'b1; rd_d = rd_q + PTR_ONE; wr_d = wr_q + PTR_ONE; cnt_d = CNT_ONE;
            end else begin
                rd_d = wr_q; cnt_d = '0;
            end
`else
            rd_d = wr_q; cnt_d = '0;
`endif
        end else begin
            if (push) begin
                wr_en = 1'b1; wr_d = wr_q + PTR_ONE;
            end else begin
                wr_en = 1'b0;
            end
            if (issue) begin
                rd_d = rd_q + PTR_ONE;
            end else begin
                rd_d = rd_q;
            end
            case ({push, issue})
                2'b10:   cnt_d = cnt_q + CNT_ONE;
                2'b01:   cnt_d = cnt_q - CNT_ONE;
                default: cnt_d = cnt_q;
            endcase
        end
    end

    // Queue storage and pointer registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < BUF_DEPTH; i++) begin
                q_pc_q[i]   <= '0;
                q_inst_q[i] <= 32'h0000_0000;
            end
            rd_q <= '0; wr_q <= '0; cnt_q <= '0;
        end else begin
            if (wr_en) begin
                q_pc_q[wr_q]   <= if_pc_i;
                q_inst_q[wr_q] <= if_inst_i;
            end
            rd_q <= rd_d; wr_q <= wr_d; cnt_q <= cnt_d;
        end
    end

    // ID/EX slot, redirect pulse, error pulse and stall counter
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            id_valid_q <= 1'b0; aluop_q <= 8'h00; alusel_q <= 3'd0; reg1_q <= '0; reg2_q <= '0;
            wd_q <= '0; wreg_q <= 1'b0; is_load_q <= 1'b0; ret_q <= '0; inst_q <= 32'h0000_0000;
            pc_q <= '0; branch_flag_q <= 1'b0; target_q <= '0; inst_err_q <= 1'b0; stall_cnt_q <= '0;
        end else begin
            if (issue) begin
                id_valid_q <= 1'b1; aluop_q <= dec_aluop; alusel_q <= dec_alusel;
                reg1_q <= op1; reg2_q <= op2; wd_q <= dec_wd; wreg_q <= dec_wreg;
                is_load_q <= dec_load; inst_q <= head_inst; pc_q <= head_pc;
`ifdef ID_DELAY_SLOT_EN
                ret_q <= head_pc + DATA_W'(8);
`else
                ret_q <= pc4;
`endif
            end else if (ex_ready_i) begin
                id_valid_q <= 1'b0;
            end
            branch_flag_q <= taken;
            if (taken) begin
                target_q <= br_target;
            end
            inst_err_q <= issue && dec_err;
            if (head_valid && load_use && (stall_cnt_q != {CNT_W{1'b1}})) begin
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            end
        end
    end

    assign id_valid_o = id_valid_q;      assign aluop_o = aluop_q;     assign alusel_o = alusel_q;
    assign reg1_o = reg1_q;              assign reg2_o = reg2_q;       assign wd_o = wd_q;
    assign wreg_o = wreg_q;              assign is_load_o = is_load_q; assign return_addr_o = ret_q;
    assign inst_o = inst_q;              assign pc_o = pc_q;           assign branch_flag_o = branch_flag_q;
    assign branch_target_o = target_q;   assign inst_err_o = inst_err_q;
    assign stall_cnt_o = stall_cnt_q;
endmodule

// File: tb/tb_id_issue_stage.sv
// ---------------------------------------------------------------------------
// tb_id_issue_stage
//  Directed bench for id_issue_stage: reset state, decode/forwarding, load-use
//  stall, branch/jump redirect with flush (expectations follow the
//  ID_DELAY_SLOT_EN build), back-pressure, unsupported opcode and async reset.
//  A tiny regfile model returns 0x1000+addr on port 1 and 0x2000+addr on port 2.
// ---------------------------------------------------------------------------
module tb_id_issue_stage;
    logic        clk, rst;
    logic        if_valid_i, if_ready_o;
    logic [31:0] if_pc_i, if_inst_i;
    logic [4:0]  reg1_addr_o, reg2_addr_o;
    logic [31:0] reg1_data_i, reg2_data_i;
    logic        ex_wreg_i, mem_wreg_i;
    logic [4:0]  ex_wd_i, mem_wd_i;
    logic [31:0] ex_wdata_i, mem_wdata_i;
    logic        id_valid_o, ex_ready_i;
    logic [7:0]  aluop_o;
    logic [2:0]  alusel_o;
    logic [31:0] reg1_o, reg2_o, return_addr_o, inst_o, pc_o, branch_target_o;
    logic [4:0]  wd_o;
    logic        wreg_o, is_load_o, branch_flag_o, inst_err_o;
    logic [15:0] stall_cnt_o;

    int err_cnt = 0;
    int chk_cnt = 0;

`ifdef ID_DELAY_SLOT_EN
    localparam logic        DS = 1'b1;
`else
    localparam logic        DS = 1'b0;
`endif

    id_issue_stage dut (
        .clk(clk), .rst(rst), .if_valid_i(if_valid_i), .if_ready_o(if_ready_o),
        .if_pc_i(if_pc_i), .if_inst_i(if_inst_i), .reg1_addr_o(reg1_addr_o), .reg2_addr_o(reg2_addr_o),
        .reg1_data_i(reg1_data_i), .reg2_data_i(reg2_data_i),
        .ex_wreg_i(ex_wreg_i), .ex_wd_i(ex_wd_i), .ex_wdata_i(ex_wdata_i),
        .mem_wreg_i(mem_wreg_i), .mem_wd_i(mem_wd_i), .mem_wdata_i(mem_wdata_i),
        .id_valid_o(id_valid_o), .ex_ready_i(ex_ready_i), .aluop_o(aluop_o), .alusel_o(alusel_o),
        .reg1_o(reg1_o), .reg2_o(reg2_o), .wd_o(wd_o), .wreg_o(wreg_o), .is_load_o(is_load_o),
        .return_addr_o(return_addr_o), .inst_o(inst_o), .pc_o(pc_o), .branch_flag_o(branch_flag_o),
        .branch_target_o(branch_target_o), .inst_err_o(inst_err_o), .stall_cnt_o(stall_cnt_o)
    );

    assign reg1_data_i = 32'h0000_1000 + {27'd0, reg1_addr_o};
    assign reg2_data_i = 32'h0000_2000 + {27'd0, reg2_addr_o};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [31:0] pc, input logic [31:0] inst);
        if_valid_i = 1'b1; if_pc_i = pc; if_inst_i = inst;
    endtask

    initial begin
        rst = 1'b0; if_valid_i = 1'b0; if_pc_i = 32'd0; if_inst_i = 32'd0;
        ex_wreg_i = 1'b0; ex_wd_i = 5'd0; ex_wdata_i = 32'd0;
        mem_wreg_i = 1'b0; mem_wd_i = 5'd0; mem_wdata_i = 32'd0; ex_ready_i = 1'b1;
        step(); step();
        check("rst_valid", {31'd0, id_valid_o}, 32'd0);
        check("rst_ready", {31'd0, if_ready_o}, 32'd1);
        check("rst_flag", {31'd0, branch_flag_o}, 32'd0);
        check("rst_err", {31'd0, inst_err_o}, 32'd0);
        check("rst_stall", {16'd0, stall_cnt_o}, 32'd0);
        check("rst_reg2", reg2_o, 32'd0);
        rst = 1'b1;
        step();

        // ORI $1,$0,0x8000
        offer(32'h0, 32'h3401_8000); step(); if_valid_i = 1'b0;
        check("ori_queued", {31'd0, id_valid_o}, 32'd0);
        step();
        check("ori_valid", {31'd0, id_valid_o}, 32'd1);
        check("ori_reg1", reg1_o, 32'd0);
        check("ori_reg2", reg2_o, 32'h0000_8000);
        check("ori_wd", {27'd0, wd_o}, 32'd1);
        check("ori_wreg", {31'd0, wreg_o}, 32'd1);
        check("ori_aluop", {24'd0, aluop_o}, 32'h25);
        check("ori_alusel", {29'd0, alusel_o}, 32'd1);
        step();
        check("ori_drain", {31'd0, id_valid_o}, 32'd0);

        // ADDU $3,$1,$2: EX beats MEM
        ex_wreg_i = 1'b1; ex_wd_i = 5'd1; ex_wdata_i = 32'd5;
        mem_wreg_i = 1'b1; mem_wd_i = 5'd1; mem_wdata_i = 32'd9;
        offer(32'h4, 32'h0022_1821); step(); if_valid_i = 1'b0; step();
        check("addu_reg1_ex", reg1_o, 32'd5);
        check("addu_reg2_rf", reg2_o, 32'h0000_2002);
        check("addu_wd", {27'd0, wd_o}, 32'd3);
        check("addu_aluop", {24'd0, aluop_o}, 32'h21);
        // SUBU $6,$1,$2: MEM only
        ex_wreg_i = 1'b0;
        offer(32'h8, 32'h0022_3023); step(); if_valid_i = 1'b0; step();
        check("subu_reg1_mem", reg1_o, 32'd9);
        check("subu_pc", pc_o, 32'h8);
        // OR $10,$3,$0: regfile on port 1, $0 stays zero even with EX writing $0
        mem_wreg_i = 1'b0; ex_wreg_i = 1'b1; ex_wd_i = 5'd0; ex_wdata_i = 32'hDEAD;
        offer(32'hC, 32'h0060_5025); step(); if_valid_i = 1'b0; step();
        check("or_reg1_rf", reg1_o, 32'h0000_1003);
        check("or_reg2_zero", reg2_o, 32'd0);
        ex_wreg_i = 1'b0;
        step();

        // LW $4,0($0) then ADDU $5,$4,$4
        offer(32'h10, 32'h8C04_0000); step();
        offer(32'h14, 32'h0084_2821); step(); if_valid_i = 1'b0;
        check("lw_valid", {31'd0, id_valid_o}, 32'd1);
        check("lw_is_load", {31'd0, is_load_o}, 32'd1);
        check("lw_wd", {27'd0, wd_o}, 32'd4);
        check("lw_stall0", {16'd0, stall_cnt_o}, 32'd0);
        step();
        check("lu_bubble", {31'd0, id_valid_o}, 32'd0);
        check("lu_stall1", {16'd0, stall_cnt_o}, 32'd1);
        mem_wreg_i = 1'b1; mem_wd_i = 5'd4; mem_wdata_i = 32'h0000_ABCD;
        step();
        check("lu_issue", {31'd0, id_valid_o}, 32'd1);
        check("lu_reg1", reg1_o, 32'h0000_ABCD);
        check("lu_reg2", reg2_o, 32'h0000_ABCD);
        check("lu_wd", {27'd0, wd_o}, 32'd5);
        check("lu_stall_hold", {16'd0, stall_cnt_o}, 32'd1);
        mem_wreg_i = 1'b0;
        step();

        // BEQ $0,$0,+4 at 0x100 with two younger instructions behind it
        ex_ready_i = 1'b0;
        offer(32'hF0, 32'h3401_0001); step();
        offer(32'h100, 32'h1000_0004); step();
        offer(32'h104, 32'h3407_0011); step();
        check("br_full", {31'd0, if_ready_o}, 32'd0);
        check("br_hold_pc", pc_o, 32'hF0);
        check("br_noflag", {31'd0, branch_flag_o}, 32'd0);
        offer(32'h108, 32'h3408_0022); ex_ready_i = 1'b1; step(); if_valid_i = 1'b0;
        check("beq_flag", {31'd0, branch_flag_o}, 32'd1);
        check("beq_target", branch_target_o, 32'h114);
        check("beq_pc", pc_o, 32'h100);
        step();
        check("beq_pulse", {31'd0, branch_flag_o}, 32'd0);
        check("beq_ds_valid", {31'd0, id_valid_o}, {31'd0, DS});
        if (DS) check("beq_ds_pc", pc_o, 32'h104);
        step();
        check("beq_flushed", {31'd0, id_valid_o}, 32'd0);
        check("beq_empty", {31'd0, if_ready_o}, 32'd1);

        // JAL at 0x200 with a same-cycle push of the next instruction
        offer(32'h200, 32'h0C00_0040); step();
        offer(32'h204, 32'h3409_0033); step(); if_valid_i = 1'b0;
        check("jal_flag", {31'd0, branch_flag_o}, 32'd1);
        check("jal_target", branch_target_o, 32'h100);
        check("jal_wd", {27'd0, wd_o}, 32'd31);
        check("jal_wreg", {31'd0, wreg_o}, 32'd1);
        check("jal_ret", return_addr_o, DS ? 32'h208 : 32'h204);
        step();
        check("jal_ds_valid", {31'd0, id_valid_o}, {31'd0, DS});
        step();

        // Back-pressure: slot held three cycles with the queue full
        ex_ready_i = 1'b0;
        offer(32'h300, 32'h340B_000A); step();
        offer(32'h304, 32'h340C_000B); step();
        offer(32'h308, 32'h340D_000C); step();
        offer(32'h30C, 32'h340E_000D);
        for (int i = 0; i < 3; i++) begin
            step();
            check("bp_ready", {31'd0, if_ready_o}, 32'd0);
            check("bp_pc", pc_o, 32'h300);
            check("bp_reg2", reg2_o, 32'hA);
        end
        if_valid_i = 1'b0; ex_ready_i = 1'b1; step();
        check("bp_b_pc", pc_o, 32'h304);
        check("bp_b_wd", {27'd0, wd_o}, 32'd12);
        step();
        check("bp_c_pc", pc_o, 32'h308);
        check("bp_c_wd", {27'd0, wd_o}, 32'd13);
        step();
        check("bp_drain", {31'd0, id_valid_o}, 32'd0);

        // Unsupported opcode 0x3F
        offer(32'h400, 32'hFC00_0000); step(); if_valid_i = 1'b0; step();
        check("err_valid", {31'd0, id_valid_o}, 32'd1);
        check("err_wreg", {31'd0, wreg_o}, 32'd0);
        check("err_aluop", {24'd0, aluop_o}, 32'd0);
        check("err_pulse", {31'd0, inst_err_o}, 32'd1);
        step();
        check("err_once", {31'd0, inst_err_o}, 32'd0);

        // Asynchronous reset mid-stream
        ex_ready_i = 1'b0;
        offer(32'h500, 32'h3401_0001); step();
        offer(32'h504, 32'h3402_0002); step(); if_valid_i = 1'b0;
        check("mid_valid", {31'd0, id_valid_o}, 32'd1);
        #2 rst = 1'b0; #1;
        check("arst_valid", {31'd0, id_valid_o}, 32'd0);
        check("arst_ready", {31'd0, if_ready_o}, 32'd1);
        check("arst_stall", {16'd0, stall_cnt_o}, 32'd0);
        check("arst_pc", pc_o, 32'd0);
        check("arst_reg2", reg2_o, 32'd0);
        rst = 1'b1; ex_ready_i = 1'b1; step();
        check("arst_empty", {31'd0, id_valid_o}, 32'd0);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end
endmodule
